hwpe_tcdm_bank_responder: RTL and testbench

HWPE_TCDM_BANK_RESPONDER -- requirements
Module: hwpe_tcdm_bank_responder

---
 rtl/hwpe_tcdm_bank_responder.sv | 111 +++++++++++
 tb/tb_hwpe_tcdm_bank_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_tcdm_bank_responder.sv
// Single-bank TCDM responder for HWPE testing: round-robin arbitration across
// NB_PORTS slave ports, one access per cycle, one-cycle read latency.
module hwpe_tcdm_bank_responder #(
   parameter int unsigned NB_PORTS  = 3,
   parameter int unsigned NB_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic [NB_PORTS-1:0]        tcdm_req_i,
   output logic [NB_PORTS-1:0]        tcdm_gnt_o,
   input  logic [NB_PORTS-1:0][31:0]  tcdm_add_i,
   input  logic [NB_PORTS-1:0]        tcdm_wen_i,
   input  logic [NB_PORTS-1:0][3:0]   tcdm_be_i,
   input  logic [NB_PORTS-1:0][31:0]  tcdm_data_i,
   output logic [NB_PORTS-1:0][31:0]  tcdm_r_data_o,
   output logic [NB_PORTS-1:0]        tcdm_r_valid_o,
   output logic [15:0]                err_cnt_o
);

   localparam int unsigned PTR_W  = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
   localparam int unsigned WORD_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
   localparam logic [32:0] SPAN   = 33'(NB_WORDS) << 2;

   logic [PTR_W-1:0]           rr_ptr;
   logic [PTR_W-1:0]           gnt_idx;
   logic                       gnt_any;
   int unsigned                cand;
   logic [15:0]                err_cnt_q;
   logic [NB_PORTS-1:0]        r_valid_q;
   logic [NB_PORTS-1:0][31:0]  r_data_q;
   logic [31:0]                mem [NB_WORDS];

   logic [31:0]                sel_add;
   logic                       sel_wen;
   logic [3:0]                 sel_be;
   logic [31:0]                sel_data;
   logic [32:0]                offset;
   logic                       in_range;
   logic [WORD_W-1:0]          widx;
   logic [PTR_W-1:0]           rr_next;

   // Round-robin pick: first requester at or after rr_ptr; nothing during reset/clear
   always_comb begin
      gnt_any    = 1'b0;
      gnt_idx    = '0;
      cand       = 0;
      tcdm_gnt_o = '0;
      for (int unsigned d = 0; d < NB_PORTS; d++) begin
         cand = (32'(rr_ptr) + d) % NB_PORTS;
         if (!gnt_any && rst_ni && !clear_i && tcdm_req_i[PTR_W'(cand)]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(cand);
         end
      end
      if (gnt_any) tcdm_gnt_o[gnt_idx] = 1'b1;
   end

   // Granted request fields and address decode
   always_comb begin
      sel_add  = tcdm_add_i[gnt_idx];
      sel_wen  = tcdm_wen_i[gnt_idx];
      sel_be   = tcdm_be_i[gnt_idx];
      sel_data = tcdm_data_i[gnt_idx];
      offset   = 33'(sel_add) - 33'(BASE_ADDR);
      in_range = !offset[32] && (offset < SPAN);
      widx     = offset[WORD_W+1:2];
      rr_next  = (gnt_idx == PTR_W'(NB_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
   end

   // Arbiter pointer, read response and error counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr    <= '0;
         err_cnt_q <= '0;
         r_valid_q <= '0;
         r_data_q  <= '0;
      end else if (clear_i) begin
         rr_ptr    <= '0;
         err_cnt_q <= '0;
         r_valid_q <= '0;
         r_data_q  <= '0;
      end else begin
         r_valid_q <= '0;
         r_data_q  <= '0;
         if (gnt_any) begin
            rr_ptr <= rr_next;
            if (sel_wen) begin
               r_valid_q[gnt_idx] <= 1'b1;
               r_data_q[gnt_idx]  <= in_range ? mem[widx] : 32'h0;
            end
            if (!in_range && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   // Storage is deliberately not reset; byte-masked write at the grant edge
   always_ff @(posedge clk_i) begin
      if (gnt_any && !sel_wen && in_range) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sel_be[b]) mem[widx][8*b +: 8] <= sel_data[8*b +: 8];
         end
      end
   end

   assign tcdm_r_valid_o = r_valid_q;
   assign tcdm_r_data_o  = r_data_q;
   assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_hwpe_tcdm_bank_responder.sv
// Directed + random bench for hwpe_tcdm_bank_responder against a bank/arbiter model.
module tb_hwpe_tcdm_bank_responder;

   localparam int unsigned NP   = 3;
   localparam int unsigned NW   = 16;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 clear_i;
   logic [NP-1:0]        req, gnt, wen, rv;
   logic [NP-1:0][31:0]  add, wdat, rdat;
   logic [NP-1:0][3:0]   be;
   logic [15:0]          err;

   always #5 clk_i = ~clk_i;

   hwpe_tcdm_bank_responder #(.NB_PORTS(NP), .NB_WORDS(NW), .BASE_ADDR(BASE)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .tcdm_req_i     (req),
      .tcdm_gnt_o     (gnt),
      .tcdm_add_i     (add),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be),
      .tcdm_data_i    (wdat),
      .tcdm_r_data_o  (rdat),
      .tcdm_r_valid_o (rv),
      .err_cnt_o      (err)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: word array, rotating priority, error count, pending responses
   logic [31:0]         mm [NW];
   int                  m_rr  = 0;
   int                  m_err = 0;
   logic [NP-1:0]       m_rv  = '0;
   logic [31:0]         m_rd [NP];
   logic [NP-1:0]       last_gnt;
   logic [NP-1:0]       last_rv;
   logic [NP-1:0][31:0] last_rd;
   logic [15:0]         last_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check all outputs against the model, then advance the model over the edge
   task automatic cycle();
      logic [NP-1:0] eg;
      int            k;
      longint        a;
      bit            inr;
      int            widx;
      #1;
      if (!rst_ni) begin
         m_rv  = '0;
         m_rr  = 0;
         m_err = 0;
      end
      eg = '0;
      k  = -1;
      if (rst_ni && !clear_i)
         for (int d = 0; d < NP; d++)
            if (k < 0 && req[(m_rr + d) % NP]) k = (m_rr + d) % NP;
      if (k >= 0) eg[k] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("r_valid", 32'(rv), 32'(m_rv));
      for (int p = 0; p < NP; p++)
         chk($sformatf("r_data[%0d]", p), rdat[p], m_rv[p] ? m_rd[p] : 32'h0);
      chk("err_cnt", 32'(err), 32'(m_err));
      last_gnt = gnt;
      last_rv  = rv;
      last_rd  = rdat;
      last_err = err;
      m_rv = '0;
      for (int p = 0; p < NP; p++) m_rd[p] = 32'h0;
      if (!rst_ni || clear_i) begin
         m_rr  = 0;
         m_err = 0;
      end else if (k >= 0) begin
         a    = longint'(add[k]);
         inr  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * NW);
         widx = inr ? int'((a - longint'(BASE)) / 4) : 0;
         if (!inr && m_err < 65535) m_err++;
         if (wen[k]) begin
            m_rv[k] = 1'b1;
            m_rd[k] = inr ? mm[widx] : 32'h0;
         end else if (inr) begin
            for (int b = 0; b < 4; b++)
               if (be[k][b]) mm[widx][8*b +: 8] = wdat[k][8*b +: 8];
         end
         m_rr = (k + 1) % NP;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      req[p]  = r;
      wen[p]  = w;
      add[p]  = a;
      wdat[p] = d;
      be[p]   = b;
   endtask

   initial begin
      rst_ni  = 1'b0;
      clear_i = 1'b0;
      req     = '1;
      wen     = '1;
      be      = '0;
      wdat    = '0;
      for (int p = 0; p < NP; p++) add[p] = BASE;
      @(posedge clk_i);
      #1;
      cycle();
      cycle();

      // Three ports contend from reset: strict rotation, no reads so memory stays untouched
      rst_ni = 1'b1;
      wen    = '0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rr_order", 32'(last_gnt), 32'(1 << (i % 3)));
      end
      req = '0;

      for (int w = 0; w < NW; w++) begin
         drive(0, 1'b1, 1'b0, BASE + 32'(4 * w), $urandom, 4'hF);
         cycle();
      end
      req = '0;

      drive(0, 1'b1, 1'b0, BASE + 32'h10, 32'hCAFEF00D, 4'hF);
      cycle();
      chk("wr_gnt", 32'(last_gnt), 32'h1);
      drive(0, 1'b1, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
      cycle();
      chk("rd_gnt", 32'(last_gnt), 32'h1);
      req = '0;
      cycle();
      chk("rd_valid", 32'(last_rv), 32'h1);
      chk("rd_data", last_rd[0], 32'hCAFEF00D);
      cycle();
      chk("rd_valid_pulse", 32'(last_rv), 32'h0);

      drive(0, 1'b1, 1'b0, BASE + 32'h20, 32'h11223344, 4'hF);
      cycle();
      drive(0, 1'b1, 1'b0, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
      cycle();
      drive(0, 1'b1, 1'b1, BASE + 32'h20, 32'h0, 4'h0);
      cycle();
      req = '0;
      cycle();
      chk("be_merge", last_rd[0], 32'h11BB33DD);

      drive(1, 1'b1, 1'b0, BASE + 32'h30, 32'h5A5A1234, 4'hF);
      cycle();
      req = '0;
      drive(2, 1'b1, 1'b1, BASE + 32'h33, 32'h0, 4'h0);
      cycle();
      req = '0;
      cycle();
      chk("raw_valid", 32'(last_rv), 32'h4);
      chk("raw_data", last_rd[2], 32'h5A5A1234);

      drive(0, 1'b1, 1'b1, BASE + 32'(4 * NW), 32'h0, 4'h0);
      cycle();
      req = '0;
      cycle();
      chk("oor_valid", 32'(last_rv), 32'h1);
      chk("oor_data", last_rd[0], 32'h0);
      chk("oor_err", 32'(last_err), 32'h1);
      clear_i = 1'b1;
      drive(1, 1'b1, 1'b1, BASE, 32'h0, 4'h0);
      cycle();
      chk("clear_no_gnt", 32'(last_gnt), 32'h0);
      clear_i = 1'b0;
      req     = '1;
      wen     = '0;
      be      = '0;
      cycle();
      chk("clear_err", 32'(last_err), 32'h0);
      chk("clear_rr", 32'(last_gnt), 32'h1);
      req = '0;

      for (int i = 0; i < 400; i++) begin
         clear_i = ($urandom % 40) == 0;
         req     = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            int unsigned r;
            r       = $urandom % 12;
            wen[p]  = $urandom % 2 == 1;
            be[p]   = 4'($urandom);
            wdat[p] = $urandom;
            if (r == 0)      add[p] = BASE - 32'(1 + $urandom % 8);
            else if (r == 1) add[p] = BASE + 32'(4 * NW) + 32'($urandom % 16);
            else             add[p] = BASE + 32'(4 * ($urandom % NW)) + 32'($urandom % 4);
         end
         cycle();
      end
      clear_i = 1'b0;
      req     = '0;
      cycle();

      // Reset lands in the cycle the read response is due
      drive(0, 1'b1, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
      cycle();
      chk("pre_rst_gnt", 32'(last_gnt), 32'h1);
      req    = '0;
      rst_ni = 1'b0;
      cycle();
      chk("rst_valid", 32'(last_rv), 32'h0);
      chk("rst_data", last_rd[0], 32'h0);
      req = '1;
      cycle();
      chk("rst_gnt", 32'(last_gnt), 32'h0);
      req    = '0;
      rst_ni = 1'b1;
      cycle();
      chk("post_rst_valid", 32'(last_rv), 32'h0);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
